// File: rtl/alu_pkg.sv
// Shared definitions for the serial add/subtract/logic unit: operation
// encodings, sequencer states and the condition-code bundle.
package alu_pkg;

    // Operation encodings as presented on the op input.
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    // Y86 condition codes produced alongside each result.
    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
        logic cout;
    } flags_t;

    // ADD and SUB go through the carry chain; AND and XOR do not.
    function automatic logic is_arith(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple adder. Besides the carry-out it exposes the
// carry into the top bit so the caller can derive signed overflow on the
// most-significant chunk.
module addsub_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    // c[i] is the carry into bit i; c[CHUNK] is the chunk carry-out.
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// Existing 1-bit full-adder cell, the building block of the chunk adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle add/subtract/logic unit for the execute stage. Operands are
// latched on accept, then processed CHUNK bits per cycle (low chunk first)
// with the carry held in a register between chunks. Result and condition
// codes are presented with a valid/ready handshake and held until taken.
module addsub_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             cout
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    // Parameter sanity: reject configurations the chunk sequencing cannot
    // represent.
    if (WIDTH < 2) begin : g_bad_width
        $error("addsub_serial: WIDTH must be at least 2");
    end
    if (CHUNK < 1) begin : g_bad_chunk
        $error("addsub_serial: CHUNK must be at least 1");
    end else if ((WIDTH % CHUNK) != 0) begin : g_bad_split
        $error("addsub_serial: WIDTH must be divisible by CHUNK");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q,  state_d;
    logic [IDXW-1:0]   idx_q,    idx_d;
    op_e               op_q,     op_d;
    logic [WIDTH-1:0]  a_q,      a_d;
    logic [WIDTH-1:0]  b_q,      b_d;      // already inverted for SUB
    logic              carry_q,  carry_d;
    logic              zacc_q,   zacc_d;   // every slice so far was zero
    logic [WIDTH-1:0]  result_q, result_d;
    flags_t            flags_q,  flags_d;

    // ------------------------------------------------------------------
    // Chunk datapath
    // ------------------------------------------------------------------
    int unsigned       base;
    logic [CHUNK-1:0]  a_slice;
    logic [CHUNK-1:0]  b_slice;
    logic [CHUNK-1:0]  sum_slice;
    logic              sum_cout;
    logic              sum_cmsb;
    logic [CHUNK-1:0]  slice;
    logic              accept;
    logic              last_chunk;

    assign base    = 32'(idx_q) * CHUNK;
    assign a_slice = a_q[base +: CHUNK];
    assign b_slice = b_q[base +: CHUNK];

    addsub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a     (a_slice),
        .b     (b_slice),
        .cin   (carry_q),
        .sum   (sum_slice),
        .cout  (sum_cout),
        .c_msb (sum_cmsb)
    );

    // Select the value written for the current chunk according to the op.
    always_comb begin
        unique case (op_q)
            OP_AND:  slice = a_slice & b_slice;
            OP_XOR:  slice = a_slice ^ b_slice;
            default: slice = sum_slice;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept     = in_valid && in_ready;
    assign last_chunk = (idx_q == LAST_IDX);

    // Next-state and datapath update: chunk processing in BUSY, hand-off in
    // DONE, and operand capture whenever a transfer is accepted.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case can leave one unassigned and infer a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        zacc_d   = zacc_q;
        result_d = result_q;
        flags_d  = flags_q;

        unique case (state_q)
            BUSY: begin
                result_d[base +: CHUNK] = slice;
                zacc_d = zacc_q & (slice == '0);
                if (is_arith(op_q)) begin
                    carry_d = sum_cout;
                end
                if (last_chunk) begin
                    // The last chunk holds the MSB, so every flag is known now.
                    state_d      = DONE;
                    flags_d.zf   = zacc_d;
                    flags_d.sf   = slice[CHUNK-1];
                    flags_d.of   = is_arith(op_q) & (sum_cmsb ^ sum_cout);
                    flags_d.cout = is_arith(op_q) & sum_cout;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // A transfer from IDLE, or from DONE while the result is being
        // taken, starts a new operation on the same edge.
        if (accept) begin
            state_d  = BUSY;
            idx_d    = '0;
            op_d     = op_e'(op);
            a_d      = a;
            b_d      = (op_e'(op) == OP_SUB) ? ~b : b;
            carry_d  = (op_e'(op) == OP_SUB);
            zacc_d   = 1'b1;
            result_d = '0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath registers are reset too, not just the
            // state, because result and flags drive outputs that must read
            // zero straight out of reset.
            state_q  <= IDLE;
            idx_q    <= '0;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q  <= state_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            zacc_q   <= zacc_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zf        = flags_q.zf;
    assign sf        = flags_q.sf;
    assign of        = flags_q.of;
    assign cout      = flags_q.cout;

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial: a 64/16 instance driven from a
// vector table and a scoreboard, plus an 8/1 instance for the
// one-bit-per-cycle configuration.
module tb_addsub_serial;
    import alu_pkg::*;

    localparam int LAT  = 4;
    localparam int LAT8 = 8;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        zf;
        logic        sf;
        logic        of;
        logic        cout;
    } vec_t;

    typedef struct packed {
        logic [63:0] res;
        logic        zf;
        logic        sf;
        logic        of;
        logic        cout;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  op;
    logic [63:0] a, b, result;
    logic        zf, sf, of, cout;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, result8;
    logic        zf8, sf8, of8, cout8;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(64), .CHUNK(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zf(zf), .sf(sf), .of(of), .cout(cout)
    );

    addsub_serial #(.WIDTH(8), .CHUNK(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .zf(zf8), .sf(sf8), .of(of8), .cout(cout8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model built from wide arithmetic and sign rules.
    function automatic exp_t model(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        exp_t        e;
        logic [64:0] s;
        e = '0;
        case (o)
            2'b00: begin
                s = {1'b0, x} + {1'b0, y};
                e.res = s[63:0]; e.cout = s[64];
                e.of = (x[63] == y[63]) && (s[63] != x[63]);
            end
            2'b01: begin
                s = {1'b0, x} + {1'b0, ~y} + 65'd1;
                e.res = s[63:0]; e.cout = s[64];
                e.of = (x[63] != y[63]) && (s[63] != x[63]);
            end
            2'b10: e.res = x & y;
            default: e.res = x ^ y;
        endcase
        e.zf = (e.res == 64'd0);
        e.sf = e.res[63];
        return e;
    endfunction

    task automatic wait_accept(input string tag);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic wait_output(input string tag, input int lat);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        check({tag, " sb_depth"}, 64'(sb.size()), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " result"}, result,     e.res);
            check({tag, " zf"},     64'(zf),    64'(e.zf));
            check({tag, " sf"},     64'(sf),    64'(e.sf));
            check({tag, " of"},     64'(of),    64'(e.of));
            check({tag, " cout"},   64'(cout),  64'(e.cout));
        end
    endtask

    // Issue one op, scramble the operand inputs after accept, and compare
    // the result when it appears.
    task automatic run_op(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                          input exp_t e, input string tag);
        op = o; a = x; b = y; in_valid = 1'b1;
        wait_accept(tag);
        @(posedge clk); #1;
        in_valid = 1'b0; op = ~o; a = ~x; b = ~y;
        sb.push_back(e);
        wait_output(tag, LAT);
        pop_compare(tag);
    endtask

    task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] er, input logic ezf, input logic esf,
                        input logic eof, input logic ecout, input string tag);
        int n = 0;
        op8 = o; a8 = x; b8 = y; in_valid8 = 1'b1;
        check({tag, " in_ready"}, 64'(in_ready8), 64'd1);
        @(posedge clk); #1;
        in_valid8 = 1'b0; a8 = ~x; b8 = ~y;
        while (!out_valid8 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " latency"}, 64'(n), 64'(LAT8));
        check({tag, " result"}, 64'(result8), 64'(er));
        check({tag, " zf"},     64'(zf8),   64'(ezf));
        check({tag, " sf"},     64'(sf8),   64'(esf));
        check({tag, " of"},     64'(of8),   64'(eof));
        check({tag, " cout"},   64'(cout8), 64'(ecout));
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t        vecs[9];
        exp_t        e;
        logic [63:0] held;
        logic        seen;

        vecs[0] = '{2'b01, 64'd5, 64'd3, 64'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{2'b01, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{2'b01, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{2'b01, 64'h1234_0000_0000_1234, 64'h1234_0000_0000_1234, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{2'b10, 64'hF0F0, 64'h0F0F, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{2'b11, 64'hFF, 64'h0F, 64'hF0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{2'b00, 64'h0000_FFFF_FFFF_FFFF, 64'd1, 64'h0001_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; op = 2'b00; a = '0; b = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; op8 = 2'b00; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready",  64'(in_ready),  64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result",    result,         64'd0);
        check("reset flags",     64'({zf, sf, of, cout}), 64'd0);
        check("reset8 in_ready", 64'(in_ready8), 64'd1);
        rst = 1'b0;

        // Table vectors, back to back with the consumer always ready.
        for (int i = 0; i < 9; i++) begin
            e = '{vecs[i].res, vecs[i].zf, vecs[i].sf, vecs[i].of, vecs[i].cout};
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, e, $sformatf("vec%0d", i));
        end

        // Random operands against the model.
        for (int i = 0; i < 6; i++) begin
            logic [1:0]  ro;
            logic [63:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            run_op(ro, ra, rb, model(ro, ra, rb), $sformatf("rand%0d", i));
        end
        @(posedge clk); #1;

        // Backpressure: result held in DONE, then a new op taken on the same
        // edge that the consumer takes the old result.
        out_ready = 1'b0;
        run_op(2'b01, 64'd5, 64'd3, model(2'b01, 64'd5, 64'd3), "bp_sub");
        held = result;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp out_valid", 64'(out_valid), 64'd1);
            check("bp in_ready",  64'(in_ready),  64'd0);
            check("bp result",    result,         held);
            check("bp flags",     64'({zf, sf, of, cout}), 64'b0001);
        end
        op = 2'b11; a = 64'hFF; b = 64'h0F; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("bp in_ready release", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp out_valid drop", 64'(out_valid), 64'd0);
        sb.push_back(model(2'b11, 64'hFF, 64'h0F));
        wait_output("bp_xor", LAT);
        pop_compare("bp_xor");
        @(posedge clk); #1;

        // Reset during the second BUSY cycle discards the operation.
        op = 2'b00; a = 64'd1; b = 64'd1; in_valid = 1'b1;
        wait_accept("rst_mid");
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid in_ready",  64'(in_ready),  64'd1);
        check("rst_mid out_valid", 64'(out_valid), 64'd0);
        check("rst_mid result",    result,         64'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        check("rst_mid no output", 64'(seen), 64'd0);

        // One bit per cycle configuration.
        run8(2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, "w8_add_wrap");
        run8(2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, "w8_add_of");
        run8(2'b01, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0, "w8_sub_borrow");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
- Parametrised, multi-cycle add/subtract/logic unit for the execute stage.
- Successor to the fixed 64-bit combinational subtractor. Adds:
  - configurable width
  - CHUNK-bits-per-cycle carry ripple, so area and timing can be traded against latency
  - valid/ready handshake on both sides
  - full Y86 condition-code generation (ZF, SF, OF, carry-out)
- Sits between decode/operand fetch and the CC/writeback logic.

Parameters:
- WIDTH, 64: operand and result width. Must be at least 2.
- CHUNK, 16: bits processed per BUSY cycle. WIDTH must be divisible by CHUNK; an elaboration-time check enforces this. CHUNK must be at least 1.
- NCHUNK, WIDTH/CHUNK: derived, localparam only.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  unit can accept; transfer occurs when in_valid && in_ready.
- op  in  2  00 ADD (a+b), 01 SUB (a-b), 10 AND, 11 XOR.
- a  in  WIDTH  first operand.
- b  in  WIDTH  second operand.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result when out_valid && out_ready.
- result  out  WIDTH  computed value.
- zf  out  1  result == 0.
- sf  out  1  result[WIDTH-1].
- of  out  1  signed overflow; 0 for AND/XOR.
- cout  out  1  raw adder carry-out. For SUB this is the carry of a + ~b + 1, so 1 means no borrow. 0 for AND/XOR.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset: state=IDLE, chunk index=0. All outputs except in_ready are 0: out_valid, result, zf, sf, of, cout. in_ready is 1.
- Reset has priority over every other event, including mid-BUSY and in DONE. An in-flight operation is discarded without producing output.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accept (in_valid && in_ready):
  - latch op and a.
  - latch b_eff = ~b for SUB, b otherwise.
  - carry register = 1 for SUB, 0 otherwise.
  - clear result, set index=0, zero-accumulator=1.
  - go to BUSY.
- BUSY, one cycle per chunk k = index, low chunk first:
  - ADD/SUB: slice = a[k] + b_eff[k] + carry. AND: a & b. XOR: a ^ b.
  - Write slice into result[k*CHUNK +: CHUNK]; update carry with the slice carry-out.
  - zero-accumulator &= (slice == 0).
  - When index == NCHUNK-1, go to DONE. Otherwise index+1.
- Operand inputs are ignored while BUSY or DONE; the latched copies are used.
- Flags, registered on entry to DONE:
  - zf = zero-accumulator.
  - sf = result MSB.
  - cout = final carry (ADD/SUB).
  - of = carry into MSB XOR carry out of MSB (ADD/SUB), computed inside the last chunk.
- DONE: out_valid=1; result and flags are held stable until out_ready.
  - out_ready && !in_valid: go to IDLE, out_valid=0 next cycle.
  - out_ready && in_valid: accept the new op in the same edge, go straight to BUSY, out_valid=0 next cycle.
- Latency: accept at edge E gives out_valid high after edge E+NCHUNK.
- Peak throughput: one op per NCHUNK+1 cycles.
- CHUNK == WIDTH gives NCHUNK=1: a single BUSY cycle, latency 1.
- Wrap-around: result is modulo 2^WIDTH; no saturation.

Decomposition:
- Package alu_pkg holds:
  - op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_XOR=2'b11
  - the state enum {IDLE, BUSY, DONE}
  - shared flag-bundle typedef {zf, sf, of, cout}
- One sub-module, addsub_chunk: combinational CHUNK-bit ripple adder built from the existing 1-bit full-adder cell.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, and carry-into-MSB, used for OF on the last chunk.
- All sequencing stays in addsub_serial.

Test Plan (WIDTH=64, CHUNK=16 unless stated; latency 4):
- SUB a=5, b=3, out_ready=1 -> out_valid exactly 4 edges after accept; result=2, zf=0, sf=0, of=0, cout=1.
- SUB a=3, b=5 -> result=0xFFFF_FFFF_FFFF_FFFE, sf=1, cout=0, of=0, zf=0.
- ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> result=0x8000_0000_0000_0000, of=1, sf=1, cout=0; SUB a=0x8000_0000_0000_0000, b=1 -> of=1, sf=0.
- SUB a=b=0x1234_0000_0000_1234 -> result=0, zf=1, cout=1. AND a=0xF0F0, b=0x0F0F -> result=0, zf=1, of=0, cout=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> result/flags stable, in_ready=0. Then out_ready=1 with in_valid=1 (XOR a=0xFF, b=0x0F) -> accepted same edge, result 0xF0 after 4 more edges.
- Assert rst during 2nd BUSY cycle -> next cycle in_ready=1, out_valid=0, result=0, no spurious output. Rerun ADD with WIDTH=8, CHUNK=1: 0xFF+0x01 -> result=0x00, cout=1, zf=1, latency 8.
